// File: rtl/irq_pending_ctrl.sv
// Edge-triggered interrupt pending register with mask and a valid/ready offer FSM.
// Optional sticky overflow flags (port ovf) are built when IRQ_OVERFLOW_EN is defined.
module irq_pending_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:1] req,
    input  logic       mask_we,
    input  logic [7:1] mask_d,
    output logic [7:1] pend,
    input  logic [2:0] idx,
    output logic       irq_valid,
    output logic [2:0] irq_idx,
    input  logic       irq_ready,
    output logic       busy
`ifdef IRQ_OVERFLOW_EN
    ,
    output logic [7:1] ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:1] req_q;
    logic [7:1] pending_q, pending_d;
    logic [7:1] mask_q;
    logic [2:0] irq_idx_q, irq_idx_d;
    logic [7:1] rise;
    logic [7:1] clr;

    assign rise = req & ~req_q;
    assign pend = pending_q & mask_q;

    // One-hot clear of the offered bit, only on the accepting cycle.
    always_comb begin
        clr = '0;
        for (int unsigned i = 1; i <= 7; i++) begin
            clr[i] = (state_q == OFFER) && irq_ready && (irq_idx_q == i[2:0]);
        end
    end

    // A coincident new rise re-sets the bit being cleared.
    assign pending_d = (pending_q & ~clr) | rise;

    always_comb begin
        state_d   = state_q;
        irq_idx_d = irq_idx_q;
        irq_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if ((pend != '0) && (idx != 3'd0)) begin
                    irq_idx_d = idx;
                    state_d   = OFFER;
                end
            end
            OFFER: begin
                irq_valid = 1'b1;
                busy      = 1'b1;
                if (irq_ready) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign irq_idx = irq_idx_q;

    // req_q tracks req even in reset so a level held through release is not seen as an edge.
    always_ff @(posedge clk) begin
        req_q <= req;
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mask_q    <= '1;
            irq_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            irq_idx_q <= irq_idx_d;
            if (mask_we) begin
                mask_q <= mask_d;
            end
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [7:1] ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | (rise & pending_q & ~clr);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl; expected offer indices are queued with stimulus
// and popped on each accepted offer. Overflow checks build only with IRQ_OVERFLOW_EN.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:1] req;
    logic       mask_we;
    logic [7:1] mask_d;
    logic [7:1] pend;
    logic [2:0] idx;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic       irq_ready;
    logic       busy;
`ifdef IRQ_OVERFLOW_EN
    logic [7:1] ovf;
`endif

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];

    irq_pending_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mask_we   (mask_we),
        .mask_d    (mask_d),
        .pend      (pend),
        .idx       (idx),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .irq_ready (irq_ready),
        .busy      (busy)
`ifdef IRQ_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Golden priority encoder: highest set bit of pend, 0 when none.
    always_comb begin
        idx = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            if (pend[i]) idx = i[2:0];
        end
    end

    // Every accepted offer must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && irq_valid && irq_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: offer idx %0d accepted, none expected", irq_idx);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (irq_idx !== e) begin
                    fails++;
                    $display("FAIL sb_idx: got %0d expected %0d", irq_idx, e);
                end
            end
        end
    end

    function automatic logic [7:1] bitv(input int i);
        logic [7:1] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; mask_we = 1'b0; mask_d = '0; irq_ready = 1'b0;
        tick(); tick();
        tests++; if (irq_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", irq_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
        tests++; if (irq_idx !== 3'd0) begin fails++; $display("FAIL rst_idx: got %0d exp 0", irq_idx); end
        tests++; if (pend !== 7'h00) begin fails++; $display("FAIL rst_pend: got %h exp 00", pend); end
`ifdef IRQ_OVERFLOW_EN
        tests++; if (ovf !== 7'h00) begin fails++; $display("FAIL rst_ovf: got %h exp 00", ovf); end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        irq_ready = 1'b1;
        exp_q.push_back(3'd3);
        req = bitv(3);
        tick();
        req = '0;
        tests++; if (pend !== bitv(3)) begin fails++; $display("FAIL single_pend_set: got %h exp %h", pend, bitv(3)); end
        tests++; if (irq_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b exp 0", irq_valid); end
        tick();
        tests++; if (irq_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b exp 1", irq_valid); end
        tests++; if (irq_idx !== 3'd3) begin fails++; $display("FAIL single_idx: got %0d exp 3", irq_idx); end
        tick();
        tests++; if ({irq_valid, busy} !== 2'b01) begin fails++; $display("FAIL single_hold: got %b exp 01", {irq_valid, busy}); end
        tests++; if (pend !== 7'h00) begin fails++; $display("FAIL single_pend_clr: got %h exp 00", pend); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got %b exp 0", busy); end
    endtask

    task automatic test_priority();
        irq_ready = 1'b1;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd2);
        req = bitv(2) | bitv(6);
        tick();
        req = '0;
        tick();
        tests++; if ({irq_valid, irq_idx} !== {1'b1, 3'd6}) begin fails++; $display("FAIL prio_first: got %b/%0d exp 1/6", irq_valid, irq_idx); end
        tick();
        tests++; if ({irq_valid, busy} !== 2'b01) begin fails++; $display("FAIL prio_hold1: got %b exp 01", {irq_valid, busy}); end
        tests++; if (pend !== bitv(2)) begin fails++; $display("FAIL prio_pend: got %h exp %h", pend, bitv(2)); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_idle: got %b exp 0", busy); end
        tick();
        tests++; if ({irq_valid, irq_idx} !== {1'b1, 3'd2}) begin fails++; $display("FAIL prio_second: got %b/%0d exp 1/2", irq_valid, irq_idx); end
        tick();
        tests++; if ({irq_valid, busy} !== 2'b01) begin fails++; $display("FAIL prio_hold2: got %b exp 01", {irq_valid, busy}); end
        tick(); tick(); tick();
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL prio_count: %0d offers outstanding exp 0", exp_q.size()); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_extra: busy %b exp 0", busy); end
    endtask

    task automatic test_mask();
        irq_ready = 1'b1;
        mask_d = 7'h7E; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        req = bitv(1);
        tick();
        req = '0;
        tick(); tick();
        tests++; if ({irq_valid, busy} !== 2'b00) begin fails++; $display("FAIL mask_blocked: got %b exp 00", {irq_valid, busy}); end
        tests++; if (pend !== 7'h00) begin fails++; $display("FAIL mask_pend_hidden: got %h exp 00", pend); end
        exp_q.push_back(3'd1);
        mask_d = 7'h7F; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        tests++; if (pend !== bitv(1)) begin fails++; $display("FAIL mask_pend_shown: got %h exp %h", pend, bitv(1)); end
        tick();
        tests++; if ({irq_valid, irq_idx} !== {1'b1, 3'd1}) begin fails++; $display("FAIL mask_offer: got %b/%0d exp 1/1", irq_valid, irq_idx); end
        tick(); tick();
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL mask_count: %0d outstanding exp 0", exp_q.size()); end
    endtask

    task automatic test_stall_collision();
        irq_ready = 1'b0;
        exp_q.push_back(3'd5);
        req = bitv(5);
        tick();
        req = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin mask_d = 7'h00; mask_we = 1'b1; end
            else if (i == 3) begin mask_d = 7'h7F; mask_we = 1'b1; end
            else mask_we = 1'b0;
            tick();
            tests++; if ({irq_valid, irq_idx} !== {1'b1, 3'd5}) begin fails++; $display("FAIL stall_%0d: got %b/%0d exp 1/5", i, irq_valid, irq_idx); end
        end
        mask_we = 1'b0;
        exp_q.push_back(3'd5);
        irq_ready = 1'b1;
        req = bitv(5);
        tick();
        req = '0;
        tests++; if (pend !== bitv(5)) begin fails++; $display("FAIL collide_pend: got %h exp %h", pend, bitv(5)); end
        tests++; if ({irq_valid, busy} !== 2'b01) begin fails++; $display("FAIL collide_hold: got %b exp 01", {irq_valid, busy}); end
        tick(); tick();
        tests++; if ({irq_valid, irq_idx} !== {1'b1, 3'd5}) begin fails++; $display("FAIL collide_reoffer: got %b/%0d exp 1/5", irq_valid, irq_idx); end
        tick(); tick();
        tests++; if (pend !== 7'h00) begin fails++; $display("FAIL collide_clr: got %h exp 00", pend); end
`ifdef IRQ_OVERFLOW_EN
        tests++; if (ovf !== 7'h00) begin fails++; $display("FAIL collide_ovf: got %h exp 00", ovf); end
`endif
    endtask

    task automatic test_reset_behaviour();
        irq_ready = 1'b1;
        reset = 1'b1; req = bitv(5);
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        tests++; if ({irq_valid, busy} !== 2'b00) begin fails++; $display("FAIL rst_held_offer: got %b exp 00", {irq_valid, busy}); end
        tests++; if (pend !== 7'h00) begin fails++; $display("FAIL rst_held_pend: got %h exp 00", pend); end
        req = '0;
        irq_ready = 1'b0;
        tick();
        req = bitv(4);
        tick();
        req = '0;
        tick();
        tests++; if (irq_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: got %b exp 1", irq_valid); end
        reset = 1'b1;
        tick();
        tests++; if ({irq_valid, busy} !== 2'b00) begin fails++; $display("FAIL rst_mid_abandon: got %b exp 00", {irq_valid, busy}); end
        tests++; if (pend !== 7'h00) begin fails++; $display("FAIL rst_mid_pend: got %h exp 00", pend); end
        reset = 1'b0;
        tick();
        tests++; if (irq_valid !== 1'b0) begin fails++; $display("FAIL rst_release1: got %b exp 0", irq_valid); end
        tick();
        tests++; if (irq_valid !== 1'b0) begin fails++; $display("FAIL rst_release2: got %b exp 0", irq_valid); end
    endtask

`ifdef IRQ_OVERFLOW_EN
    task automatic test_overflow();
        irq_ready = 1'b0;
        req = bitv(4);
        tick();
        req = '0;
        tick();
        req = bitv(4);
        tick();
        req = '0;
        tests++; if (ovf !== 7'b0001000) begin fails++; $display("FAIL ovf_set: got %b exp 0001000", ovf); end
        exp_q.push_back(3'd4);
        irq_ready = 1'b1;
        tick(); tick(); tick(); tick();
        tests++; if (ovf !== 7'b0001000) begin fails++; $display("FAIL ovf_sticky: got %b exp 0001000", ovf); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (ovf !== 7'h00) begin fails++; $display("FAIL ovf_reset: got %b exp 0000000", ovf); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_stall_collision();
        test_reset_behaviour();
`ifdef IRQ_OVERFLOW_EN
        test_overflow();
`endif
        tick(); tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d offers never accepted, exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
